// File: rtl/seq_alu_mac.sv
// seq_alu_mac: valid/ready ALU with an iterative shift-add multiplier and a MAC accumulator.
// Optional build macro SEQ_ALU_MAC_SATURATE_EN: saturating accumulator with sticky acc_sat.
module seq_alu_mac #(
  parameter int WIDTH     = 32,
  parameter int ACC_WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic [3:0]       alu_control,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] alu_result,
  output logic             zero_flag,
  output logic             illegal_op,
  output logic             busy,
  output logic             acc_sat
);
  localparam int SHW = $clog2(WIDTH);

  // state | meaning
  // IDLE  | nothing held, ready for an op
  // BUSY  | shift-add multiply running, one multiplier bit per cycle
  // DONE  | result held on alu_result until the consumer takes it
  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  localparam logic [3:0] OP_AND    = 4'b0000;
  localparam logic [3:0] OP_OR     = 4'b0001;
  localparam logic [3:0] OP_ADD    = 4'b0010;
  localparam logic [3:0] OP_XOR    = 4'b0011;
  localparam logic [3:0] OP_SUB    = 4'b0100;
  localparam logic [3:0] OP_SLT    = 4'b0101;
  localparam logic [3:0] OP_SLTU   = 4'b0110;
  localparam logic [3:0] OP_SLL    = 4'b0111;
  localparam logic [3:0] OP_SRL    = 4'b1000;
  localparam logic [3:0] OP_SRA    = 4'b1001;
  localparam logic [3:0] OP_MUL    = 4'b1010;
  localparam logic [3:0] OP_MAC    = 4'b1011;
  localparam logic [3:0] OP_ACCCLR = 4'b1100;
  localparam logic [3:0] OP_ACCRD  = 4'b1101;

  state_t                 state_q;
  logic                   out_valid_q;
  logic [WIDTH-1:0]       alu_result_q;
  logic                   zero_q;
  logic                   illegal_q;
  logic                   busy_q;
  logic [ACC_WIDTH-1:0]   acc_q;
  logic [WIDTH-1:0]       mcand_q;
  logic [2*WIDTH-1:0]     prod_q;
  logic                   neg_q;
  logic                   mac_q;
  logic [SHW-1:0]         cnt_q;

  logic                   accept;
  logic                   consume;
  logic                   is_iter;
  logic                   is_illegal;
  logic [SHW-1:0]         shamt;
  logic [WIDTH-1:0]       alu_res;
  logic [WIDTH-1:0]       a_mag;
  logic [WIDTH-1:0]       b_mag;
  logic [WIDTH:0]         hi_sum;
  logic [2*WIDTH-1:0]     prod_step;
  logic [2*WIDTH-1:0]     prod_final;
  logic [ACC_WIDTH-1:0]   acc_add;
  logic [ACC_WIDTH-1:0]   acc_sum;
  logic [ACC_WIDTH-1:0]   acc_new;
  logic [WIDTH-1:0]       fin_res;

  assign in_ready   = (state_q == S_IDLE) || ((state_q == S_DONE) && out_ready);
  assign accept     = in_valid && in_ready;
  assign consume    = out_valid_q && out_ready;
  assign is_iter    = (alu_control == OP_MUL) || (alu_control == OP_MAC);
  assign is_illegal = (alu_control == 4'b1110) || (alu_control == 4'b1111);
  assign shamt      = in2[SHW-1:0];

  always_comb begin
    alu_res = '0;
    case (alu_control)
      OP_AND:    alu_res = in1 & in2;
      OP_OR:     alu_res = in1 | in2;
      OP_ADD:    alu_res = in1 + in2;
      OP_XOR:    alu_res = in1 ^ in2;
      OP_SUB:    alu_res = in1 - in2;
      OP_SLT:    alu_res = {{(WIDTH-1){1'b0}}, ($signed(in1) < $signed(in2))};
      OP_SLTU:   alu_res = {{(WIDTH-1){1'b0}}, (in1 < in2)};
      OP_SLL:    alu_res = in1 << shamt;
      OP_SRL:    alu_res = in1 >> shamt;
      OP_SRA:    alu_res = $signed(in1) >>> shamt;
      OP_ACCRD:  alu_res = acc_q[WIDTH-1:0];
      default:   alu_res = '0;
    endcase
  end

  // Multiplier works on magnitudes; the most negative value maps onto itself as unsigned.
  assign a_mag = in1[WIDTH-1] ? (-in1) : in1;
  assign b_mag = in2[WIDTH-1] ? (-in2) : in2;

  // Right-shifting product register: multiplier bits in the low half retire one per cycle.
  assign hi_sum     = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + (prod_q[0] ? {1'b0, mcand_q} : '0);
  assign prod_step  = {hi_sum, prod_q[WIDTH-1:1]};
  assign prod_final = neg_q ? (-prod_step) : prod_step;
  assign acc_add    = ACC_WIDTH'($signed(prod_final));
  assign acc_sum    = acc_q + acc_add;

`ifdef SEQ_ALU_MAC_SATURATE_EN
  logic acc_sat_q;
  logic acc_ovf;
  assign acc_ovf = (acc_q[ACC_WIDTH-1] == acc_add[ACC_WIDTH-1]) &&
                   (acc_sum[ACC_WIDTH-1] != acc_q[ACC_WIDTH-1]);
  assign acc_new = !acc_ovf ? acc_sum :
                   acc_q[ACC_WIDTH-1] ? {1'b1, {(ACC_WIDTH-1){1'b0}}} : {1'b0, {(ACC_WIDTH-1){1'b1}}};
  assign acc_sat = acc_sat_q;
`else
  assign acc_new = acc_sum;
  assign acc_sat = 1'b0;
`endif

  assign fin_res = mac_q ? acc_new[WIDTH-1:0] : prod_final[WIDTH-1:0];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      out_valid_q  <= 1'b0;
      alu_result_q <= '0;
      zero_q       <= 1'b0;
      illegal_q    <= 1'b0;
      busy_q       <= 1'b0;
      acc_q        <= '0;
      mcand_q      <= '0;
      prod_q       <= '0;
      neg_q        <= 1'b0;
      mac_q        <= 1'b0;
      cnt_q        <= '0;
`ifdef SEQ_ALU_MAC_SATURATE_EN
      acc_sat_q    <= 1'b0;
`endif
    end else if (accept) begin
      // Accept is only possible from IDLE or from DONE while the held result is consumed.
      if (is_iter) begin
        state_q     <= S_BUSY;
        busy_q      <= 1'b1;
        out_valid_q <= 1'b0;
        mcand_q     <= a_mag;
        prod_q      <= {{WIDTH{1'b0}}, b_mag};
        neg_q       <= in1[WIDTH-1] ^ in2[WIDTH-1];
        mac_q       <= (alu_control == OP_MAC);
        cnt_q       <= SHW'(WIDTH-1);
      end else begin
        state_q      <= S_DONE;
        busy_q       <= 1'b0;
        out_valid_q  <= 1'b1;
        alu_result_q <= alu_res;
        zero_q       <= (alu_res == '0);
        illegal_q    <= is_illegal;
        if (alu_control == OP_ACCCLR) begin
          acc_q <= '0;
`ifdef SEQ_ALU_MAC_SATURATE_EN
          acc_sat_q <= 1'b0;
`endif
        end
      end
    end else begin
      case (state_q)
        S_BUSY: begin
          prod_q <= prod_step;
          cnt_q  <= cnt_q - SHW'(1);
          if (cnt_q == '0) begin
            state_q      <= S_DONE;
            busy_q       <= 1'b0;
            out_valid_q  <= 1'b1;
            alu_result_q <= fin_res;
            zero_q       <= (fin_res == '0);
            illegal_q    <= 1'b0;
            if (mac_q) begin
              acc_q <= acc_new;
`ifdef SEQ_ALU_MAC_SATURATE_EN
              if (acc_ovf) acc_sat_q <= 1'b1;
`endif
            end
          end
        end
        S_DONE: begin
          if (consume) begin
            state_q     <= S_IDLE;
            out_valid_q <= 1'b0;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign out_valid  = out_valid_q;
  assign alu_result = alu_result_q;
  assign zero_flag  = zero_q;
  assign illegal_op = illegal_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_seq_alu_mac.sv
// Self-checking bench for seq_alu_mac (WIDTH=32, ACC_WIDTH=64); directed steps plus random ops
// against an arithmetic reference model. Honours SEQ_ALU_MAC_SATURATE_EN when defined.
module tb_seq_alu_mac;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in1 = '0;
  logic [31:0] in2 = '0;
  logic [3:0]  alu_control = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] alu_result;
  logic        zero_flag;
  logic        illegal_op;
  logic        busy;
  logic        acc_sat;

  int     n_assert = 0;
  int     n_fail   = 0;
  longint m_acc    = 0;
  logic   m_sat    = 1'b0;

  always #5 clk = ~clk;

  seq_alu_mac #(.WIDTH(32), .ACC_WIDTH(64)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in1(in1), .in2(in2), .alu_control(alu_control), .out_valid(out_valid),
    .out_ready(out_ready), .alu_result(alu_result), .zero_flag(zero_flag),
    .illegal_op(illegal_op), .busy(busy), .acc_sat(acc_sat)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: plain arithmetic on the opcode rules; updates the model accumulator.
  task automatic model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] r);
    longint p;
    longint s;
    p = longint'($signed(a)) * longint'($signed(b));
    r = '0;
    case (op)
      4'd0:  r = a & b;
      4'd1:  r = a | b;
      4'd2:  r = a + b;
      4'd3:  r = a ^ b;
      4'd4:  r = a - b;
      4'd5:  r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd6:  r = (a < b) ? 32'd1 : 32'd0;
      4'd7:  r = a << b[4:0];
      4'd8:  r = a >> b[4:0];
      4'd9:  r = $signed(a) >>> b[4:0];
      4'd10: r = p[31:0];
      4'd11: begin
        s = m_acc + p;
`ifdef SEQ_ALU_MAC_SATURATE_EN
        if ((m_acc < 0) == (p < 0) && (s < 0) != (m_acc < 0)) begin
          s = (m_acc < 0) ? 64'sh8000_0000_0000_0000 : 64'sh7FFF_FFFF_FFFF_FFFF;
          m_sat = 1'b1;
        end
`endif
        m_acc = s;
        r = s[31:0];
      end
      4'd12: begin m_acc = 0; m_sat = 1'b0; end
      4'd13: r = m_acc[31:0];
      default: r = '0;
    endcase
  endtask

  task automatic run_op(input string tag, input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] b);
    logic [31:0] exp_r;
    int          exp_lat;
    int          lat;
    bit          seen;
    model(op, a, b, exp_r);
    exp_lat = (op == 4'd10 || op == 4'd11) ? 33 : 1;
    @(negedge clk);
    in_valid = 1'b1; alu_control = op; in1 = a; in2 = b;
    lat = 0;
    while (!in_ready && lat < 100) begin @(negedge clk); lat++; end
    check({tag, ":in_ready"}, in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0; in1 = $urandom; in2 = $urandom; alu_control = 4'($urandom);
    lat = 0; seen = 0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk);
      lat++;
      if (out_valid) seen = 1;
      else if (exp_lat > 1) begin
        check({tag, ":busy"}, busy, 1);
        check({tag, ":in_ready_busy"}, in_ready, 0);
        in_valid = 1'($urandom);
      end
    end
    in_valid = 1'b0;
    check({tag, ":latency"}, lat, exp_lat);
    check({tag, ":result"}, alu_result, exp_r);
    check({tag, ":zero"}, zero_flag, exp_r == 0);
    check({tag, ":illegal"}, illegal_op, op >= 4'd14);
    check({tag, ":acc_sat"}, acc_sat, m_sat);
  endtask

  initial begin
    logic [31:0] ra;
    logic [31:0] rb;
    logic [3:0]  rop;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst:out_valid", out_valid, 0);
    check("rst:result", alu_result, 0);
    check("rst:zero", zero_flag, 0);
    check("rst:illegal", illegal_op, 0);
    check("rst:busy", busy, 0);
    check("rst:acc_sat", acc_sat, 0);
    check("rst:in_ready", in_ready, 1);
    rst_n = 1'b1;

    // Single-cycle ops, compares, shifts
    run_op("add", 4'd2, 32'd23, 32'd42);
    check("add:const", alu_result, 32'd65);
    run_op("sub", 4'd4, 32'd42, 32'd42);
    check("sub:zero_const", zero_flag, 1);
    run_op("and", 4'd0, 32'd23, 32'd42);
    run_op("or", 4'd1, 32'd23, 32'd42);
    run_op("xor", 4'd3, 32'd23, 32'd42);
    run_op("slt", 4'd5, 32'hFFFF_FFFF, 32'd1);
    run_op("sltu", 4'd6, 32'hFFFF_FFFF, 32'd1);
    run_op("sra", 4'd9, 32'h8000_0000, 32'd4);
    check("sra:const", alu_result, 32'hF800_0000);
    run_op("srl", 4'd8, 32'h8000_0000, 32'd31);
    run_op("sll", 4'd7, 32'd1, 32'h25);
    check("sll:const", alu_result, 32'h20);

    // Multiplier and MAC sequence
    run_op("mul", 4'd10, 32'hFFFF_FFFD, 32'd7);
    check("mul:const", alu_result, 32'hFFFF_FFEB);
    run_op("mul_min", 4'd10, 32'h8000_0000, 32'h8000_0000);
    run_op("mul_zero", 4'd10, 32'h1234_5678, 32'd0);
    run_op("acc_clr", 4'd12, 32'd5, 32'd6);
    run_op("mac1", 4'd11, 32'd3, 32'd4);
    run_op("mac2", 4'd11, 32'hFFFF_FFFE, 32'd5);
    check("mac2:const", alu_result, 32'd2);
    run_op("acc_rd", 4'd13, 32'd0, 32'd0);
    run_op("illegal", 4'd15, 32'd9, 32'd9);
    run_op("illegal14", 4'd14, 32'd1, 32'd1);
    run_op("acc_rd2", 4'd13, 32'd0, 32'd0);

    // Backpressure then back-to-back issue on the consume cycle
    out_ready = 1'b0;
    @(negedge clk);
    in_valid = 1'b1; alu_control = 4'd2; in1 = 32'd1; in2 = 32'd1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp:out_valid", out_valid, 1);
      check("bp:result", alu_result, 32'd2);
      check("bp:in_ready", in_ready, 0);
    end
    out_ready = 1'b1; in_valid = 1'b1; alu_control = 4'd2; in1 = 32'd2; in2 = 32'd2;
    #1;
    check("b2b:in_ready", in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("b2b:out_valid", out_valid, 1);
    check("b2b:result", alu_result, 32'd4);
    @(negedge clk);
    @(negedge clk);
    check("b2b:drained", out_valid, 0);

    // Reset in the middle of a multiply
    @(negedge clk);
    in_valid = 1'b1; alu_control = 4'd10; in1 = 32'd1000; in2 = 32'd77;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (10) @(negedge clk);
    check("rstmul:busy_before", busy, 1);
    rst_n = 1'b0;
    @(posedge clk); #1;
    check("rstmul:out_valid", out_valid, 0);
    check("rstmul:busy", busy, 0);
    check("rstmul:in_ready", in_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;
    m_acc = 0; m_sat = 1'b0;
    run_op("rstmul:acc_rd", 4'd13, 32'd0, 32'd0);

    // Accumulator overflow: wraps by default, pins at max when saturation is built in
    run_op("ovf:clr", 4'd12, 32'd0, 32'd0);
    for (int i = 0; i < 4; i++) run_op("ovf:mac", 4'd11, 32'h7FFF_FFFF, 32'h7FFF_FFFF);
    run_op("ovf:rd", 4'd13, 32'd0, 32'd0);
`ifdef SEQ_ALU_MAC_SATURATE_EN
    check("sat:pinned", alu_result, 32'hFFFF_FFFF);
    check("sat:flag", acc_sat, 1);
`else
    check("wrap:low", alu_result, 32'h0000_0004);
    check("wrap:flag", acc_sat, 0);
`endif
    run_op("ovf:clr2", 4'd12, 32'd0, 32'd0);

    // Random ops with occasional boundary operands
    for (int i = 0; i < 40; i++) begin
      rop = 4'($urandom_range(0, 15));
      ra = $urandom;
      rb = $urandom;
      if ($urandom_range(0, 5) == 0) ra = 32'h8000_0000;
      if ($urandom_range(0, 5) == 0) rb = 32'd0;
      run_op("rand", rop, ra, rb);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
